// File: rtl/victim_write_buffer.sv
// Victim write buffer: queues evicted dirty lines, drains them to data memory in
// the background and forwards buffered lines to cache reads before going to memory.
module victim_write_buffer #(
  parameter int LINE_SIZE       = 16,
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int DEPTH           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         is_input_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]   addr,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [8*LINE_SIZE-1:0]       din,
  output logic                         is_output_valid,
  output logic [8*LINE_SIZE-1:0]       dout,
  output logic                         mem_ready,
  output logic                         dm_is_input_valid,
  output logic [LINE_ADDR_WIDTH-1:0]   dm_addr,
  output logic                         dm_mem_read,
  output logic                         dm_mem_write,
  output logic [8*LINE_SIZE-1:0]       dm_din,
  input  logic                         dm_is_output_valid,
  input  logic [8*LINE_SIZE-1:0]       dm_dout,
  input  logic                         dm_mem_ready,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [31:0]                  number_of_forward_hits
);

  localparam int DW = 8 * LINE_SIZE;
  localparam int AW = LINE_ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RESP, RD_ISSUE, RD_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [31:0]     hits_q, hits_d;
  logic [AW-1:0]   addr_mem_q [DEPTH];
  logic [DW-1:0]   data_mem_q [DEPTH];

  logic            accept_s, wr_s, rd_s, hit_s, drain_s, rd_issue_s, rd_done_s;
  logic [DW-1:0]   hit_data_s;

  // Associative lookup; later (newer) entries override older matches.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_mem_q[head_q + PW'(i)] == addr)) begin
        hit_s      = 1'b1;
        hit_data_s = data_mem_q[head_q + PW'(i)];
      end else begin
        hit_data_s = hit_data_s;
      end
    end
  end

  // Request acceptance, drain decision and data-memory port muxing.
  always_comb begin
    mem_ready  = reset && (state_q == IDLE) && (count_q < CW'(DEPTH));
    accept_s   = is_input_valid && mem_ready;
    wr_s       = accept_s && mem_write;
    rd_s       = accept_s && !mem_write && mem_read;
    drain_s    = ((state_q == IDLE) || (state_q == RESP)) && (count_q != '0) && dm_mem_ready;
    rd_issue_s = (state_q == RD_ISSUE);
    rd_done_s  = (state_q == RD_WAIT) && dm_is_output_valid;

    dm_is_input_valid = rd_issue_s || drain_s;
    dm_mem_read       = rd_issue_s;
    dm_mem_write      = drain_s;
    if (rd_issue_s) begin
      dm_addr = rd_addr_q;
    end else if (drain_s) begin
      dm_addr = addr_mem_q[head_q];
    end else begin
      dm_addr = '0;
    end
    dm_din = drain_s ? data_mem_q[head_q] : '0;

    is_output_valid        = (state_q == RESP) || rd_done_s;
    dout                   = rd_done_s ? dm_dout : dout_q;
    occupancy              = count_q;
    number_of_forward_hits = hits_q;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    dout_d    = dout_q;
    hits_d    = hits_q;
    head_d    = drain_s ? head_q + PW'(1) : head_q;
    tail_d    = wr_s ? tail_q + PW'(1) : tail_q;
    count_d   = count_q + CW'(wr_s) - CW'(drain_s);
    case (state_q)
      IDLE: begin
        if (rd_s && hit_s) begin
          state_d = RESP;
          dout_d  = hit_data_s;
          hits_d  = hits_q + 32'd1;
        end else if (rd_s) begin
          state_d   = RD_ISSUE;
          rd_addr_d = addr;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:     state_d = IDLE;
      RD_ISSUE: state_d = dm_mem_ready ? RD_WAIT : RD_ISSUE;
      RD_WAIT: begin
        if (dm_is_output_valid) begin
          state_d = IDLE;
          dout_d  = dm_dout;
        end else begin
          state_d = RD_WAIT;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      dout_q    <= '0;
      hits_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      dout_q    <= dout_d;
      hits_q    <= hits_d;
    end
  end

  // Line storage; validity is tracked purely by head/count, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      addr_mem_q[tail_q] <= addr;
      data_mem_q[tail_q] <= din;
    end
  end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed bench for victim_write_buffer: stimulus pushes expected responses and
// data-memory issues into queues, a negedge monitor pops and compares them.
module tb_victim_write_buffer;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid, mem_read, mem_write;
  logic [27:0]   addr;
  logic [127:0]  din;
  logic          is_output_valid;
  logic [127:0]  dout;
  logic          mem_ready;
  logic          dm_is_input_valid, dm_mem_read, dm_mem_write;
  logic [27:0]   dm_addr;
  logic [127:0]  dm_din;
  logic          dm_is_output_valid;
  logic [127:0]  dm_dout;
  logic          dm_mem_ready;
  logic [2:0]    occupancy;
  logic [31:0]   number_of_forward_hits;

  typedef struct packed {
    logic         wr;
    logic [27:0]  a;
    logic [127:0] d;
  } dm_t;

  dm_t          dm_exp[$];
  logic [127:0] resp_exp[$];
  int           vectors = 0;
  int           miscompares = 0;

  victim_write_buffer #(.LINE_SIZE(16), .LINE_ADDR_WIDTH(28), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
    .is_output_valid(is_output_valid), .dout(dout), .mem_ready(mem_ready),
    .dm_is_input_valid(dm_is_input_valid), .dm_addr(dm_addr),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_din(dm_din),
    .dm_is_output_valid(dm_is_output_valid), .dm_dout(dm_dout),
    .dm_mem_ready(dm_mem_ready), .occupancy(occupancy),
    .number_of_forward_hits(number_of_forward_hits)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dat(input logic [27:0] a, input logic [3:0] tag);
    return {4{tag, a}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d);
    is_input_valid = 1'b1;
    mem_write      = 1'b1;
    mem_read       = 1'b0;
    addr           = a;
    din            = d;
    tick();
    idle_in();
  endtask

  // Monitor: every response pulse and every accepted dm issue must match the next expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (is_output_valid) begin
        if (resp_exp.size() == 0) begin
          chk("unexpected_resp", 128'd1, 128'd0);
        end else begin
          chk("resp_dout", dout, resp_exp.pop_front());
        end
      end
      if (dm_is_input_valid && dm_mem_ready) begin
        if (dm_exp.size() == 0) begin
          chk("unexpected_dm_issue", {100'd0, dm_addr}, 128'd0);
        end else begin
          dm_t e;
          e = dm_exp.pop_front();
          chk("dm_write", {127'd0, dm_mem_write}, {127'd0, e.wr});
          chk("dm_read", {127'd0, dm_mem_read}, {127'd0, !e.wr});
          chk("dm_addr", {100'd0, dm_addr}, {100'd0, e.a});
          chk("dm_din", dm_din, e.d);
        end
      end
    end
  end

  initial begin
    logic [2:0] occ_exp [9];
    occ_exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    reset = 1'b0;
    idle_in();
    addr = 28'h0; din = 128'h0;
    dm_is_output_valid = 1'b0; dm_dout = 128'h0; dm_mem_ready = 1'b1;

    // Reset held while requests are presented.
    is_input_valid = 1'b1; mem_write = 1'b1; addr = 28'h10; din = dat(28'h10, 4'hA);
    tick(); tick();
    chk("rst_occupancy", {125'd0, occupancy}, 128'd0);
    chk("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
    chk("rst_dm_valid", {127'd0, dm_is_input_valid}, 128'd0);
    chk("rst_dm_addr", {100'd0, dm_addr}, 128'd0);
    chk("rst_dm_din", dm_din, 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_hits", {96'd0, number_of_forward_hits}, 128'd0);
    idle_in();
    reset = 1'b1;
    #1;
    chk("post_rst_mem_ready", {127'd0, mem_ready}, 128'd1);

    // Fill to DEPTH with memory stalled, then drain one per cycle in order.
    dm_mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(28'(i * 16), dat(28'(i * 16), 4'hA));
    chk("full_occupancy", {125'd0, occupancy}, 128'd4);
    chk("full_mem_ready", {127'd0, mem_ready}, 128'd0);
    for (int i = 1; i <= 4; i++) dm_exp.push_back('{1'b1, 28'(i * 16), dat(28'(i * 16), 4'hA)});
    dm_mem_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("drain_occupancy", {125'd0, occupancy}, 128'(4 - k));
    end

    // Duplicate address: newest entry forwarded.
    dm_mem_ready = 1'b0;
    wr(28'h55, dat(28'h55, 4'hA));
    wr(28'h55, dat(28'h55, 4'hB));
    is_input_valid = 1'b1; mem_read = 1'b1; addr = 28'h55;
    resp_exp.push_back(dat(28'h55, 4'hB));
    tick();
    idle_in();
    chk("hit_valid", {127'd0, is_output_valid}, 128'd1);
    chk("hit_count", {96'd0, number_of_forward_hits}, 128'd1);
    tick();
    chk("hit_pulse_end", {127'd0, is_output_valid}, 128'd0);
    chk("dout_hold", dout, dat(28'h55, 4'hB));
    chk("hit_occupancy", {125'd0, occupancy}, 128'd2);

    // Miss with two pending entries: dm read goes first, drains wait for the response.
    is_input_valid = 1'b1; mem_read = 1'b1; addr = 28'h99;
    tick();
    idle_in();
    chk("miss_rd_issue", {127'd0, dm_mem_read}, 128'd1);
    chk("miss_rd_addr", {100'd0, dm_addr}, 128'h99);
    dm_exp.push_back('{1'b0, 28'h99, 128'd0});
    dm_exp.push_back('{1'b1, 28'h55, dat(28'h55, 4'hA)});
    dm_exp.push_back('{1'b1, 28'h55, dat(28'h55, 4'hB)});
    dm_mem_ready = 1'b1;
    tick();
    chk("wait_no_drain", {127'd0, dm_is_input_valid}, 128'd0);
    tick();
    chk("wait_no_resp", {127'd0, is_output_valid}, 128'd0);
    tick();
    resp_exp.push_back(128'hC0FFEE);
    dm_is_output_valid = 1'b1; dm_dout = 128'hC0FFEE;
    #1;
    chk("miss_valid", {127'd0, is_output_valid}, 128'd1);
    chk("miss_occupancy", {125'd0, occupancy}, 128'd2);
    tick();
    dm_is_output_valid = 1'b0; dm_dout = 128'h0;
    chk("miss_dout_hold", dout, 128'hC0FFEE);
    tick(); tick();
    chk("post_miss_drained", {125'd0, occupancy}, 128'd0);
    chk("miss_hits_unchanged", {96'd0, number_of_forward_hits}, 128'd1);

    // Six lines through a four-entry FIFO: pointers wrap, order kept.
    for (int i = 0; i < 6; i++) dm_exp.push_back('{1'b1, 28'(256 + i), dat(28'(256 + i), 4'hE)});
    for (int k = 0; k < 9; k++) begin
      dm_mem_ready = (k >= 3);
      if (k < 6) begin
        is_input_valid = 1'b1; mem_write = 1'b1; addr = 28'(256 + k); din = dat(28'(256 + k), 4'hE);
      end
      tick();
      idle_in();
      chk("wrap_occupancy", {125'd0, occupancy}, {125'd0, occ_exp[k]});
    end

    // Reset during RD_WAIT discards the buffered line and the outstanding read.
    dm_mem_ready = 1'b0;
    wr(28'h77, dat(28'h77, 4'h7));
    is_input_valid = 1'b1; mem_read = 1'b1; addr = 28'hAB;
    tick();
    idle_in();
    dm_exp.push_back('{1'b0, 28'hAB, 128'd0});
    dm_mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_rst_occupancy", {125'd0, occupancy}, 128'd0);
    chk("rw_rst_valid", {127'd0, is_output_valid}, 128'd0);
    tick();
    reset = 1'b1;
    dm_is_output_valid = 1'b1; dm_dout = 128'hDEAD;
    #1;
    chk("rw_ignored_valid", {127'd0, is_output_valid}, 128'd0);
    chk("rw_mem_ready", {127'd0, mem_ready}, 128'd1);
    chk("rw_hits", {96'd0, number_of_forward_hits}, 128'd0);
    tick();
    dm_is_output_valid = 1'b0;
    tick(); tick();

    chk("resp_queue_empty", 128'(resp_exp.size()), 128'd0);
    chk("dm_queue_empty", 128'(dm_exp.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
